sipo_deframer_9_bit: RTL and testbench

Serial-to-parallel receive stage that rebuilds WIDTH-bit words from the LSB-first bit stream produced by the upstream parallel-in/serial-out shift register. A `start` strobe marks the first bit. Bits are collected by a two-state FSM with a bit counter. Completed words are queued in a 2-entry output buffer and leave through a valid/ready handshake. Overflow and framing errors are flagged for the control logic.

---
 rtl/sipo_deframer_9_bit_if.sv | 22 ++
 rtl/sipo_deframer_9_bit.sv | 126 ++++++++++++
 tb/tb_sipo_deframer_9_bit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sipo_deframer_9_bit_if.sv
// rtl/sipo_deframer_9_bit_if.sv - parallel word output handshake of the deframer
interface sipo_deframer_9_bit_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] out_parallel;
  logic             out_valid;
  logic             out_ready;

  // Producer side: the deframer presents words
  modport master (
    output out_parallel,
    output out_valid,
    input  out_ready
  );

  // Consumer side: downstream logic accepts words
  modport slave (
    input  out_parallel,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sipo_deframer_9_bit.sv
// rtl/sipo_deframer_9_bit.sv - LSB-first serial-to-parallel deframer with 2-entry output buffer
module sipo_deframer_9_bit #(
  parameter int WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_serial,
  input  logic                      clr_ovf,
  output logic                      busy,
  output logic                      overflow,
  output logic                      frame_err,
  sipo_deframer_9_bit_if.master     out
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] new_word;
  logic [WIDTH-1:0] tail;
  logic [1:0]       occ;
  logic             push;
  logic             pop;

  // Completion happens when the last bit is sampled; the word is assembled on the fly
  always_comb begin
    push              = (state == SHIFT) && !start && (cnt == CW'(WIDTH - 1));
    new_word          = sreg;
    new_word[WIDTH-1] = in_serial;
  end

  assign pop           = out.out_valid & out.out_ready;
  assign out.out_valid = (occ != 2'd0);

  // Bit-collection FSM; busy mirrors the next state so it is a clean register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg  <= {{(WIDTH-1){1'b0}}, in_serial};
            cnt   <= CW'(1);
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (start) begin
            // Abort: drop partial word, this cycle is bit 0 of a new one
            sreg      <= {{(WIDTH-1){1'b0}}, in_serial};
            cnt       <= CW'(1);
            frame_err <= 1'b1;
          end else if (cnt == CW'(WIDTH - 1)) begin
            sreg  <= '0;
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            sreg[cnt] <= in_serial;
            cnt       <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry FIFO: head lives directly in the output register, tail behind it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out.out_parallel <= '0;
      tail             <= '0;
      occ              <= 2'd0;
      overflow         <= 1'b0;
    end else begin
      if (push && (occ == 2'd2) && !pop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            out.out_parallel <= new_word;
            occ              <= 2'd1;
          end else if (occ == 2'd1) begin
            tail <= new_word;
            occ  <= 2'd2;
          end
        end
        2'b01: begin
          if (occ == 2'd1) begin
            out.out_parallel <= '0;
            occ              <= 2'd0;
          end else begin
            out.out_parallel <= tail;
            tail             <= '0;
            occ              <= 2'd1;
          end
        end
        2'b11: begin
          if (occ == 2'd1) begin
            out.out_parallel <= new_word;
          end else begin
            out.out_parallel <= tail;
            tail             <= new_word;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sipo_deframer_9_bit.sv
// tb/tb_sipo_deframer_9_bit.sv - scoreboard bench for sipo_deframer_9_bit
module tb_sipo_deframer_9_bit;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic in_serial;
  logic clr_ovf;
  logic busy;
  logic overflow;
  logic frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int bc;
  logic [8:0] exp_word;
  logic [8:0] sb[$];

  sipo_deframer_9_bit_if #(.WIDTH(9)) bus ();

  sipo_deframer_9_bit #(.WIDTH(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_serial (in_serial),
    .clr_ovf   (clr_ovf),
    .busy      (busy),
    .overflow  (overflow),
    .frame_err (frame_err),
    .out       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every accepted word must match the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) fe_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", int'(bus.out_parallel), -1);
        end else begin
          exp_word = sb.pop_front();
          check("word", int'(bus.out_parallel), int'(exp_word));
        end
      end
    end
  end

  task automatic send_bits(input logic [8:0] w, input int n, input bit push_exp,
                           input bit ready_last, output int busy_cycles);
    busy_cycles = 0;
    if (push_exp) sb.push_back(w);
    for (int i = 0; i < n; i++) begin
      start     = (i == 0);
      in_serial = w[i];
      if (ready_last && i == n - 1) bus.out_ready = 1'b1;
      @(negedge clk);
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    in_serial = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_serial = 1'b0; clr_ovf = 1'b0; bus.out_ready = 1'b0;
    idle(2);
    check("rst_data", int'(bus.out_parallel), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_ferr", int'(frame_err), 0);
    rst = 1'b1;
    idle(1);

    // Single word
    bus.out_ready = 1'b1;
    send_bits(9'h1A5, 9, 1, 0, bc);
    check("single_busy", bc, 8);
    @(negedge clk);
    check("single_valid", int'(bus.out_valid), 1);
    check("single_busy_drop", int'(busy), 0);
    @(negedge clk);
    check("single_once", int'(bus.out_valid), 0);
    @(posedge clk); #1;

    // Back-to-back
    send_bits(9'h0FF, 9, 1, 0, bc);
    check("b2b_busy0", bc, 8);
    send_bits(9'h100, 9, 1, 0, bc);
    check("b2b_busy1", bc, 8);
    send_bits(9'h155, 9, 1, 0, bc);
    check("b2b_busy2", bc, 8);
    @(negedge clk);
    check("b2b_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    idle(2);
    check("b2b_ferr", fe_cnt, 0);

    // Backpressure and overflow
    bus.out_ready = 1'b0;
    send_bits(9'h001, 9, 1, 0, bc);
    send_bits(9'h002, 9, 1, 0, bc);
    @(negedge clk);
    check("bp_valid", int'(bus.out_valid), 1);
    check("bp_head", int'(bus.out_parallel), 9'h001);
    check("bp_ovf_pre", int'(overflow), 0);
    @(posedge clk); #1;
    send_bits(9'h003, 9, 0, 0, bc);
    @(negedge clk);
    check("bp_ovf", int'(overflow), 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    idle(3);
    check("bp_drained", int'(bus.out_valid), 0);
    check("bp_ovf_sticky", int'(overflow), 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("bp_ovf_clr", int'(overflow), 0);

    // Full buffer with a same-cycle pop on the third completion
    bus.out_ready = 1'b0;
    send_bits(9'h0C3, 9, 1, 0, bc);
    send_bits(9'h13C, 9, 1, 0, bc);
    send_bits(9'h0AA, 9, 1, 1, bc);
    idle(4);
    check("full_pop_ovf", int'(overflow), 0);
    check("full_pop_empty", int'(bus.out_valid), 0);

    // Abort mid-word
    send_bits(9'h1FF, 4, 0, 0, bc);
    send_bits(9'h033, 9, 1, 0, bc);
    check("abort_busy", bc, 9);
    idle(3);
    check("abort_ferr", fe_cnt, 1);

    // Reset mid-word with one word buffered
    bus.out_ready = 1'b0;
    send_bits(9'h0F0, 9, 0, 0, bc);
    send_bits(9'h1FF, 5, 0, 0, bc);
    rst = 1'b0;
    #1;
    check("mid_rst_data", int'(bus.out_parallel), 0);
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ovf", int'(overflow), 0);
    check("mid_rst_ferr", int'(frame_err), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    send_bits(9'h12C, 9, 1, 0, bc);
    @(negedge clk);
    check("post_rst_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    idle(3);
    check("sb_drain", sb.size(), 0);
    check("final_ferr", fe_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
